syncfifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO's write port among `NREQ` producers in the systolic datapath. Each producer presents a val/rdy stream; the arbiter selects one producer per cycle, drives the FIFO write enable and data, and stalls every producer while the FIFO reports full. An optional burst lock keeps one producer granted until it marks the last word of a packet.

---
 rtl/syncfifo_arb_pkg.sv | 15 +
 rtl/rr_priority_select.sv | 42 ++++
 rtl/syncfifo_write_arbiter.sv | 113 +++++++++++
 tb/tb_syncfifo_write_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/syncfifo_arb_pkg.sv
// Shared types and helpers for the synchronous-FIFO write arbiter.
//   arb_state_e : arbiter state (IDLE re-arbitrates, BURST holds the owner)
//   rr_next     : round-robin wrap-increment of a requester index
package syncfifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic int rr_next(input int idx, input int nreq);
    return (idx == nreq - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector.
// Finds the first set bit of req, searching upward from prio and wrapping
// from NREQ-1 back to 0.
//   req     : request vector
//   prio    : index where the search starts
//   gnt     : one-hot grant (all zero when req is zero)
//   gnt_idx : binary index of the granted bit (0 when nothing is granted)
module rr_priority_select #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   prio,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [NREQ-1:0]   msk;
  logic [2*NREQ-1:0] dbl;
  logic              found;

  // The low half holds only the requests at or above prio and the high half
  // holds every request. A plain lowest-bit search over the double-width
  // vector therefore visits prio..NREQ-1 first and then wraps to 0..prio-1.
  always_comb begin
    for (int i = 0; i < NREQ; i++) msk[i] = req[i] && (i >= int'(prio));
    dbl = {req, msk};
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < 2*NREQ; k++) begin
      if (!found && dbl[k]) begin
        found   = 1'b1;
        gnt_idx = IW'(k % NREQ);
      end
    end
    for (int j = 0; j < NREQ; j++) gnt[j] = found && (int'(gnt_idx) == j);
  end

endmodule

// File: rtl/syncfifo_write_arbiter.sv
// Round-robin arbiter that shares one synchronous FIFO write port among NREQ
// producers. At most one word is transferred per cycle, and every producer
// stalls while the FIFO is full.
// Optional burst lock (macro SYNCFIFO_ARB_BURST_LOCK_EN): once a producer is
// granted, it keeps the port until it writes a word with req_last set.
// Ports:
//   clk, rst        : clock; synchronous active-low reset
//   req_val/req_rdy : per-producer handshake (req_rdy is one-hot or zero)
//   req_msg         : packed words, producer i at [i*DW +: DW]
//   req_last        : last word of a packet (used only with the burst lock)
//   fifo_full       : FIFO full flag
//   fifo_wen        : FIFO write enable
//   fifo_wdata      : FIFO write data (0 when there is no write)
//   owner           : index of the current or last granted producer
//   locked          : burst lock held
module syncfifo_write_arbiter
  import syncfifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_val,
  input  logic [NREQ*DW-1:0] req_msg,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_rdy,
  input  logic               fifo_full,
  output logic               fifo_wen,
  output logic [DW-1:0]      fifo_wdata,
  output logic [IW-1:0]      owner,
  output logic               locked
);

  logic [IW-1:0]   prio_q;
  logic [IW-1:0]   owner_q;
  logic [NREQ-1:0] sel_gnt;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   grant_idx;
  logic            xfer;

  rr_priority_select #(.NREQ(NREQ), .IW(IW)) u_sel (
    .req     (req_val),
    .prio    (prio_q),
    .gnt     (sel_gnt),
    .gnt_idx (sel_idx)
  );

`ifdef SYNCFIFO_ARB_BURST_LOCK_EN
  arb_state_e state_q, state_d;

  // In BURST the ready is driven from the owner and fifo_full alone. It does
  // not look at req_val, so a producer can drop valid and still keep the port.
  always_comb begin
    req_rdy   = '0;
    grant_idx = sel_idx;
    if (state_q == ARB_BURST) begin
      grant_idx = owner_q;
      if (!fifo_full) req_rdy[owner_q] = 1'b1;
    end else if (!fifo_full) begin
      req_rdy = sel_gnt;
    end
  end

  always_comb begin
    state_d = state_q;
    if (xfer) begin
      case (state_q)
        ARB_IDLE:  if (!req_last[grant_idx]) state_d = ARB_BURST;
        ARB_BURST: if (req_last[owner_q])    state_d = ARB_IDLE;
        default:   state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  assign locked = (state_q == ARB_BURST);
`else
  logic unused_last;
  assign unused_last = ^req_last;

  always_comb begin
    req_rdy   = '0;
    grant_idx = sel_idx;
    if (!fifo_full) req_rdy = sel_gnt;
  end

  assign locked = 1'b0;
`endif

  assign xfer       = |(req_val & req_rdy);
  assign fifo_wen   = xfer;
  assign fifo_wdata = xfer ? req_msg[grant_idx*DW +: DW] : '0;
  assign owner      = owner_q;

  // Within a burst grant_idx equals the owner, so the same update also gives
  // prio = owner+1 when the packet ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q  <= '0;
      owner_q <= '0;
    end else if (xfer) begin
      prio_q  <= IW'(rr_next(int'(grant_idx), NREQ));
      owner_q <= grant_idx;
    end
  end

endmodule

// File: tb/tb_syncfifo_write_arbiter.sv
module tb_syncfifo_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IW   = 2;
`ifdef SYNCFIFO_ARB_BURST_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_val;
  logic [NREQ*DW-1:0] req_msg;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_rdy;
  logic               fifo_full;
  logic               fifo_wen;
  logic [DW-1:0]      fifo_wdata;
  logic [IW-1:0]      owner;
  logic               locked;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] sb[$];

  syncfifo_write_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_msg    (req_msg),
    .req_last   (req_last),
    .req_rdy    (req_rdy),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .owner      (owner),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each FIFO write pops the word the bench expected when it drove the cycle.
  always @(negedge clk) begin
    if (fifo_wen === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_wen", 64'(fifo_wen), 64'(0));
      else                chk("wdata", 64'(fifo_wdata), 64'(sb.pop_front()));
    end
  end

  // One cycle: drive at posedge+1, check at negedge. exp < 0 means no write.
  task automatic step(input logic [3:0] v, input logic f, input logic [3:0] l,
                      input int exp, input logic [3:0] erdy, input logic elk);
    req_val   = v;
    fifo_full = f;
    req_last  = l;
    for (int i = 0; i < NREQ; i++) req_msg[i*DW +: DW] = $urandom;
    if (exp >= 0) sb.push_back(req_msg[exp*DW +: DW]);
    @(negedge clk);
    chk("rdy",  64'(req_rdy),  64'(erdy));
    chk("lock", 64'(locked),   64'(elk));
    chk("wen",  64'(fifo_wen), 64'(exp >= 0));
    if (exp < 0) chk("wdata_idle", 64'(fifo_wdata), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; req_val = '0; req_msg = '0; req_last = '0; fifo_full = 1'b0;
    step(4'b0000, 0, 4'b0000, -1, 4'b0000, 0);
    step(4'b0000, 0, 4'b0000, -1, 4'b0000, 0);
    chk("rst_owner", 64'(owner), 64'(0));
    rst = 1'b1;

    // Round robin with all producers valid: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++)
      step(4'b1111, 0, 4'b1111, i % 4, 4'b0001 << (i % 4), 0);
    chk("rr_owner", 64'(owner), 64'(3));

    // prio=2 then only 0,1 valid: the search wraps to 0
    step(4'b0010, 0, 4'b1111, 1, 4'b0010, 0);
    step(4'b0011, 0, 4'b1111, 0, 4'b0001, 0);
    chk("wrap_owner", 64'(owner), 64'(0));
    step(4'b1111, 0, 4'b1111, 1, 4'b0010, 0);   // prio was 1

    // full stall: nothing moves; prio 2 survives
    for (int i = 0; i < 3; i++) step(4'b1111, 1, 4'b1111, -1, 4'b0000, 0);
    chk("stall_owner", 64'(owner), 64'(1));
    step(4'b1111, 0, 4'b1111, 2, 4'b0100, 0);
    step(4'b0000, 0, 4'b0000, -1, 4'b0000, 0);
    step(4'b0001, 0, 4'b1111, 0, 4'b0001, 0);   // prio 3 wraps to 0

`ifdef SYNCFIFO_ARB_BURST_LOCK_EN
    // producer 1 burst of 4 while others stay valid
    step(4'b1111, 0, 4'b0000, 1, 4'b0010, 0);
    step(4'b1111, 0, 4'b0000, 1, 4'b0010, 1);
    step(4'b1111, 0, 4'b0000, 1, 4'b0010, 1);
    step(4'b1111, 0, 4'b0010, 1, 4'b0010, 1);
    step(4'b1111, 0, 4'b1111, 2, 4'b0100, 0);
    // producer 3 drops valid mid-burst; full also holds the lock
    step(4'b1111, 0, 4'b0000, 3, 4'b1000, 0);
    step(4'b0111, 0, 4'b0000, -1, 4'b1000, 1);
    step(4'b0111, 0, 4'b0000, -1, 4'b1000, 1);
    step(4'b1111, 1, 4'b0000, -1, 4'b0000, 1);
    chk("burst_owner", 64'(owner), 64'(3));
    step(4'b1111, 0, 4'b1000, 3, 4'b1000, 1);
`else
    // req_last ignored: re-arbitrate every word
    step(4'b1111, 0, 4'b0000, 1, 4'b0010, 0);
    step(4'b1111, 0, 4'b0000, 2, 4'b0100, 0);
    step(4'b1111, 0, 4'b0000, 3, 4'b1000, 0);
`endif

    // reset while producer 1 holds the port (burst when the lock is built in)
    step(4'b0010, 0, 4'b0000, 1, 4'b0010, 0);
    rst = 1'b0;
    step(4'b0000, 0, 4'b0000, -1, LK ? 4'b0010 : 4'b0000, LK);
    rst = 1'b1;
    chk("mid_rst_owner", 64'(owner), 64'(0));
    chk("mid_rst_lock",  64'(locked), 64'(0));
    step(4'b1110, 0, 4'b1111, 1, 4'b0010, 0);   // prio back to 0
    step(4'b0000, 0, 4'b0000, -1, 4'b0000, 0);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
